// File: rtl/zeroskip_pkg.sv
// Shared types and helpers for the zero-skip row controller.
package zeroskip_pkg;

  localparam int ELEM_W = 8;

  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic [1:0] {
    NZ_FULL = 2'd0,
    NZ_HALF = 2'd1,
    NZ_QUAR = 2'd2
  } nz_mode_e;

  // Number of slots kept per compressed group.
  function automatic int nz_of(nz_mode_e mode, int m);
    int r;
    case (mode)
      NZ_HALF: r = m / 2;
      NZ_QUAR: r = m / 4;
      default: r = m;
    endcase
    return r;
  endfunction

  // Number of compressed groups packed into one output beat.
  function automatic int grp_per_beat(nz_mode_e mode);
    int r;
    case (mode)
      NZ_HALF: r = 2;
      NZ_QUAR: r = 4;
      default: r = 1;
    endcase
    return r;
  endfunction

  // The reserved select code falls back to full mode.
  function automatic nz_mode_e decode_sel(logic [1:0] sel);
    nz_mode_e r;
    case (sel)
      2'd1:    r = NZ_HALF;
      2'd2:    r = NZ_QUAR;
      default: r = NZ_FULL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/zeroskip_packer.sv
// Packs 1, 2 or 4 compressed groups into an M-lane beat and holds it for
// the downstream consumer.
module zeroskip_packer #(
  parameter int M      = 16,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  grp_vld,
  input  logic [M*DATA_W-1:0]   grp_slots,
  input  logic                  grp_last,
  output logic                  grp_rdy,
  output logic                  idle,
  output logic [M*DATA_W-1:0]   out_dout,
  output logic [M-1:0]          out_lane_vld,
  output logic                  out_vld,
  output logic                  out_last,
  input  logic                  out_rdy
);
  import zeroskip_pkg::*;

  logic [1:0]          cnt;
  logic [M*DATA_W-1:0] acc;
  logic [M-1:0]        acc_lv;
  logic [M*DATA_W-1:0] merged;
  logic [M-1:0]        merged_lv;
  logic                complete;
  logic                out_free;
  logic                take;
  int                  nz;
  int                  kgrp;
  int                  base;

  // Merge the incoming group into the accumulator at its lane window and
  // decide whether this group closes the beat.
  always_comb begin
    nz        = nz_of(nz_mode_e'(mode), M);
    kgrp      = grp_per_beat(nz_mode_e'(mode));
    base      = int'(cnt) * nz;
    merged    = acc;
    merged_lv = acc_lv;
    for (int l = 0; l < M; l++) begin
      if (l >= base && l < base + nz) begin
        merged[l*DATA_W +: DATA_W] = grp_slots[(l-base)*DATA_W +: DATA_W];
        merged_lv[l]               = 1'b1;
      end
    end
    complete = grp_last || (int'(cnt) == kgrp - 1);
    out_free = !out_vld || out_rdy;
    grp_rdy  = !complete || out_free;
    take     = grp_vld && grp_rdy;
    idle     = (cnt == 2'd0) && !out_vld;
  end

  // Accumulator and output register; a closed beat leaves the accumulator
  // zeroed so padding lanes of a partial beat read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= 2'd0;
      acc          <= '0;
      acc_lv       <= '0;
      out_dout     <= '0;
      out_lane_vld <= '0;
      out_vld      <= 1'b0;
      out_last     <= 1'b0;
    end else if (take && complete) begin
      out_dout     <= merged;
      out_lane_vld <= merged_lv;
      out_last     <= grp_last;
      out_vld      <= 1'b1;
      acc          <= '0;
      acc_lv       <= '0;
      cnt          <= 2'd0;
    end else begin
      if (take) begin
        acc    <= merged;
        acc_lv <= merged_lv;
        cnt    <= cnt + 2'd1;
      end
      if (out_vld && out_rdy) out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/zeroskip_row_mac_param.sv
// Zero-skip row controller: compresses activation groups under a nonzero
// mask and hands them to the packer feeding one MAC row.
module zeroskip_row_mac_param #(
  parameter int M      = 16,
  parameter int DIN_W  = 32,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              nz_sel_i,
  input  logic [DIN_W-1:0]        znz_din,
  input  logic                    znz_din_vld_i,
  output logic                    znz_din_rdy_o,
  input  logic [DIN_W*DATA_W-1:0] act_din,
  input  logic                    act_din_vld_i,
  output logic                    act_din_rdy_o,
  input  logic                    last_i,
  output logic [M*DATA_W-1:0]     act_enc_dout,
  output logic [M-1:0]            lane_vld_o,
  output logic                    act_enc_vld_o,
  output logic                    act_enc_last_o,
  input  logic                    act_enc_rdy_i,
  output logic                    nz_ovf_o
);
  import zeroskip_pkg::*;

  nz_mode_e            mode_q;
  nz_mode_e            mode_eff;
  logic                idle;
  logic                pk_idle;
  logic                pk_rdy;
  logic                s1_vld;
  logic                s1_last;
  logic [M*DATA_W-1:0] s1_slots;
  logic                s1_free;
  logic                accept;
  logic [M*DATA_W-1:0] cmp_slots;
  logic                cmp_ovf;
  int                  cmp_cnt;
  int                  cmp_nz;

  // Handshake and mode selection; a new mode is used for the group that is
  // accepted on the idle cycle, matching what mode_q latches at that edge.
  always_comb begin
    idle          = !s1_vld && pk_idle;
    mode_eff      = idle ? decode_sel(nz_sel_i) : mode_q;
    s1_free       = !s1_vld || pk_rdy;
    accept        = znz_din_vld_i && act_din_vld_i && s1_free && rst_n;
    znz_din_rdy_o = accept;
    act_din_rdy_o = accept;
  end

  // Compressor: keep the first NZ marked elements in index order.
  always_comb begin
    cmp_slots = '0;
    cmp_cnt   = 0;
    cmp_nz    = nz_of(mode_eff, M);
    for (int i = 0; i < DIN_W; i++) begin
      if (znz_din[i]) begin
        if (cmp_cnt < cmp_nz)
          cmp_slots[cmp_cnt*DATA_W +: DATA_W] = act_din[i*DATA_W +: DATA_W];
        cmp_cnt = cmp_cnt + 1;
      end
    end
    cmp_ovf = (cmp_cnt > cmp_nz);
  end

  // Stage 1 control, mode latch and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      mode_q   <= NZ_FULL;
      nz_ovf_o <= 1'b0;
    end else begin
      if (accept)      s1_vld <= 1'b1;
      else if (pk_rdy) s1_vld <= 1'b0;
      if (idle)        mode_q <= mode_eff;
      if (accept && cmp_ovf) nz_ovf_o <= 1'b1;
    end
  end

  // Stage 1 data register (p0 -> p1 boundary).
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_slots <= cmp_slots;
      s1_last  <= last_i;
    end
  end

  zeroskip_packer #(
    .M      (M),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode_q),
    .grp_vld      (s1_vld),
    .grp_slots    (s1_slots),
    .grp_last     (s1_last),
    .grp_rdy      (pk_rdy),
    .idle         (pk_idle),
    .out_dout     (act_enc_dout),
    .out_lane_vld (lane_vld_o),
    .out_vld      (act_enc_vld_o),
    .out_last     (act_enc_last_o),
    .out_rdy      (act_enc_rdy_i)
  );

endmodule

// File: tb/tb_zeroskip_row_mac_param.sv
// Self-checking bench for zeroskip_row_mac_param with a beat-level model.
module tb_zeroskip_row_mac_param;
  localparam int M      = 16;
  localparam int DIN_W  = 32;
  localparam int DATA_W = 8;
  localparam int BW     = M * DATA_W;
  localparam int AW     = DIN_W * DATA_W;

  logic            clk;
  logic            rst_n;
  logic [1:0]      nz_sel_i;
  logic [DIN_W-1:0] znz_din;
  logic            znz_din_vld_i;
  logic            znz_din_rdy_o;
  logic [AW-1:0]   act_din;
  logic            act_din_vld_i;
  logic            act_din_rdy_o;
  logic            last_i;
  logic [BW-1:0]   act_enc_dout;
  logic [M-1:0]    lane_vld_o;
  logic            act_enc_vld_o;
  logic            act_enc_last_o;
  logic            act_enc_rdy_i;
  logic            nz_ovf_o;

  zeroskip_row_mac_param #(.M(M), .DIN_W(DIN_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .nz_sel_i       (nz_sel_i),
    .znz_din        (znz_din),
    .znz_din_vld_i  (znz_din_vld_i),
    .znz_din_rdy_o  (znz_din_rdy_o),
    .act_din        (act_din),
    .act_din_vld_i  (act_din_vld_i),
    .act_din_rdy_o  (act_din_rdy_o),
    .last_i         (last_i),
    .act_enc_dout   (act_enc_dout),
    .lane_vld_o     (lane_vld_o),
    .act_enc_vld_o  (act_enc_vld_o),
    .act_enc_last_o (act_enc_last_o),
    .act_enc_rdy_i  (act_enc_rdy_i),
    .nz_ovf_o       (nz_ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] d;
    logic [M-1:0]  lv;
    logic          last;
  } beat_t;

  beat_t              exp_q[$];
  logic [DATA_W-1:0]  m_lane [M];
  logic [M-1:0]       m_lv;
  int                 m_cnt;
  logic               exp_ovf;
  bit                 rand_rdy;
  int                 n_checks;
  int                 n_fail;

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < M; l++) m_lane[l] = '0;
    m_lv  = '0;
    m_cnt = 0;
  endtask

  // Reference: compress to first NZ marked elements, then fill K groups per beat.
  task automatic model_accept(logic [DIN_W-1:0] mask, logic [AW-1:0] act,
                              logic last, int mode);
    int nz;
    int k;
    int pc;
    logic [DATA_W-1:0] slots [M];
    beat_t b;
    nz = (mode == 1) ? M/2 : (mode == 2) ? M/4 : M;
    k  = (mode == 1) ? 2   : (mode == 2) ? 4   : 1;
    pc = 0;
    for (int j = 0; j < M; j++) slots[j] = '0;
    for (int i = 0; i < DIN_W; i++) begin
      if (mask[i]) begin
        if (pc < nz) slots[pc] = act[i*DATA_W +: DATA_W];
        pc++;
      end
    end
    if (pc > nz) exp_ovf = 1'b1;
    for (int j = 0; j < nz; j++) begin
      m_lane[m_cnt*nz + j] = slots[j];
      m_lv[m_cnt*nz + j]   = 1'b1;
    end
    m_cnt++;
    if (m_cnt == k || last) begin
      for (int l = 0; l < M; l++) b.d[l*DATA_W +: DATA_W] = m_lane[l];
      b.lv   = m_lv;
      b.last = last;
      exp_q.push_back(b);
      model_clear();
    end
  endtask

  task automatic send_group(logic [DIN_W-1:0] mask, logic [AW-1:0] act,
                            logic last, int mode, bit rnd);
    bit done;
    bit vz;
    bit va;
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      vz = rnd ? 1'($urandom & 1) : 1'b1;
      va = rnd ? 1'($urandom & 1) : 1'b1;
      znz_din       = mask;
      act_din       = act;
      last_i        = last;
      znz_din_vld_i = vz;
      act_din_vld_i = va;
      #1;
      if (!(vz && va)) begin
        check("single_side_rdy", {254'd0, znz_din_rdy_o, act_din_rdy_o}, 256'd0);
      end else if (znz_din_rdy_o && act_din_rdy_o) begin
        model_accept(mask, act, last, mode);
        done = 1;
        @(posedge clk);
        #1;
      end
    end
    znz_din_vld_i = 1'b0;
    act_din_vld_i = 1'b0;
    if (!done) check("send_timeout", 256'd0, 256'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !act_enc_vld_o) ok = 1;
    end
    if (!ok) check("drain_timeout", 256'd0, 256'd1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rand_act();
    logic [AW-1:0] a;
    for (int j = 0; j < AW/32; j++) a[j*32 +: 32] = $urandom;
    return a;
  endfunction

  // Output monitor: every valid cycle must show the scoreboard head, which
  // also proves the beat is held stable through stalls.
  initial begin
    act_enc_rdy_i = 1'b1;
    forever begin
      @(negedge clk);
      act_enc_rdy_i = rand_rdy ? 1'($urandom & 1) : 1'b1;
      #1;
      if (rst_n === 1'b1 && act_enc_vld_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 256'd1, 256'd0);
        end else begin
          check("dout", 256'(act_enc_dout), 256'(exp_q[0].d));
          check("lane_vld", 256'(lane_vld_o), 256'(exp_q[0].lv));
          check("last", 256'(act_enc_last_o), 256'(exp_q[0].last));
          if (act_enc_rdy_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [DIN_W-1:0] mk;
    logic lst;
    n_checks = 0;
    n_fail   = 0;
    rand_rdy = 0;
    exp_ovf  = 1'b0;
    model_clear();
    rst_n = 1'b0;
    nz_sel_i = 2'd0;
    znz_din = '0;
    act_din = '0;
    last_i = 1'b0;
    znz_din_vld_i = 1'b1;
    act_din_vld_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 256'(act_enc_vld_o), 256'd0);
    check("rst_dout", 256'(act_enc_dout), 256'd0);
    check("rst_lv", 256'(lane_vld_o), 256'd0);
    check("rst_last", 256'(act_enc_last_o), 256'd0);
    check("rst_ovf", 256'(nz_ovf_o), 256'd0);
    check("rst_rdy", {254'd0, znz_din_rdy_o, act_din_rdy_o}, 256'd0);
    znz_din_vld_i = 1'b0;
    act_din_vld_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0, identity activations, first 16 elements marked.
    for (int i = 0; i < DIN_W; i++) a[i*DATA_W +: DATA_W] = 8'(i);
    send_group(32'h0000_FFFF, a, 1'b0, 0, 0);
    @(negedge clk); #1;
    check("lat_stage1", 256'(act_enc_vld_o), 256'd0);
    @(negedge clk); #1;
    check("lat_out", 256'(act_enc_vld_o), 256'd1);
    check("t1_lv", 256'(lane_vld_o), 256'h FFFF);
    check("t1_lane5", 256'(act_enc_dout[5*DATA_W +: DATA_W]), 256'd5);
    check("t1_lane15", 256'(act_enc_dout[15*DATA_W +: DATA_W]), 256'd15);
    drain();

    // Mode 1, low byte group then high byte group form one beat.
    nz_sel_i = 2'd1;
    a = rand_act();
    b = rand_act();
    send_group(32'h0000_00FF, a, 1'b0, 1, 0);
    send_group(32'hFF00_0000, b, 1'b0, 1, 0);
    drain();
    check("t2_ovf", 256'(nz_ovf_o), 256'd0);

    // Mode 2, partial last beat after three groups.
    nz_sel_i = 2'd2;
    send_group(32'h0000_0F00, rand_act(), 1'b0, 2, 0);
    send_group(32'h1100_0011, rand_act(), 1'b0, 2, 0);
    send_group(32'h8000_0007, rand_act(), 1'b1, 2, 0);
    drain();
    check("t3_ovf", 256'(nz_ovf_o), 256'd0);

    // Mode 2 overflow: only elements 0..3 survive, flag becomes sticky.
    send_group(32'hFFFF_FFFF, a, 1'b1, 2, 0);
    drain();
    check("ovf_set", 256'(nz_ovf_o), 256'd1);

    // Mode change mid-row is deferred until the pipeline is idle.
    send_group(32'h000F_0000, rand_act(), 1'b0, 2, 0);
    nz_sel_i = 2'd0;
    send_group(32'h0000_F000, rand_act(), 1'b0, 2, 0);
    send_group(32'h0F00_0000, rand_act(), 1'b1, 2, 0);
    drain();
    send_group(32'h0F0F_0F0F, rand_act(), 1'b0, 0, 0);
    drain();
    check("ovf_sticky", 256'(nz_ovf_o), 256'd1);

    // Randomized mode 1 traffic with random valids and backpressure.
    nz_sel_i = 2'd1;
    rand_rdy = 1;
    for (int g = 0; g < 1000; g++) begin
      mk  = $urandom & $urandom;
      lst = (g == 999) ? 1'b1 : (($urandom & 7) == 0);
      send_group(mk, rand_act(), lst, 1, 1);
    end
    drain();
    rand_rdy = 0;
    repeat (2) @(negedge clk);
    check("rand_ovf", 256'(nz_ovf_o), 256'(exp_ovf));

    // Reset with one group held in the accumulator.
    send_group(32'h0000_00FF, rand_act(), 1'b0, 1, 0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_vld", 256'(act_enc_vld_o), 256'd0);
    check("mrst_dout", 256'(act_enc_dout), 256'd0);
    check("mrst_lv", 256'(lane_vld_o), 256'd0);
    check("mrst_ovf", 256'(nz_ovf_o), 256'd0);
    znz_din_vld_i = 1'b1;
    act_din_vld_i = 1'b1;
    #1;
    check("mrst_rdy", {254'd0, znz_din_rdy_o, act_din_rdy_o}, 256'd0);
    znz_din_vld_i = 1'b0;
    act_din_vld_i = 1'b0;
    exp_q.delete();
    model_clear();
    exp_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_group(32'h00FF_0000, rand_act(), 1'b1, 1, 0);
    drain();
    check("post_rst_ovf", 256'(nz_ovf_o), 256'd0);
    check("leftover_beats", 256'(exp_q.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
